// File: rtl/rgb_pack_pkg.sv
// Shared types and constants for the 24-bit RGB to 32-bit AXI4-Stream packer.
package rgb_pack_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [3:0] KEEP_FULL = 4'hF;
  localparam logic [3:0] KEEP_3    = 4'b0111;
  localparam logic [3:0] KEEP_2    = 4'b0011;
  localparam logic [3:0] KEEP_1    = 4'b0001;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    FLUSH  = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_pack_lane_mux.sv
// Byte-lane steering: merges the residual bytes with the incoming pixel (or
// pads a flush word) and computes the residual left over for the next phase.
module rgb_pack_lane_mux
  import rgb_pack_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic [1:0]         phase,
  input  logic [PIXEL_W-1:0] res,
  input  logic [PIXEL_W-1:0] pix,
  input  logic               flush,
  input  logic               eol,
  output logic [31:0]        data,
  output logic [3:0]         keep,
  output logic [PIXEL_W-1:0] res_nxt,
  output logic               emit
);

  always_comb begin
    data    = '0;
    keep    = '0;
    res_nxt = res;
    emit    = 1'b0;
    if (flush) begin
      // In FLUSH the phase register holds the post-increment phase, so it
      // tells how many residual bytes are left (2 -> two bytes, 3 -> one).
      res_nxt = '0;
      case (phase)
        2'd2: begin
          emit = 1'b1;
          data = {PAD_BYTE, PAD_BYTE, res[15:0]};
          keep = KEEP_2;
        end
        2'd3: begin
          emit = 1'b1;
          data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, res[7:0]};
          keep = KEEP_1;
        end
        default: ;
      endcase
    end else begin
      case (phase)
        2'd0: begin
          res_nxt = pix;
          if (eol) begin
            emit = 1'b1;
            data = {PAD_BYTE, pix};
            keep = KEEP_3;
          end
        end
        2'd1: begin
          emit    = 1'b1;
          data    = {pix[7:0], res[23:0]};
          keep    = KEEP_FULL;
          res_nxt = {8'h00, pix[23:8]};
        end
        2'd2: begin
          emit    = 1'b1;
          data    = {pix[15:0], res[15:0]};
          keep    = KEEP_FULL;
          res_nxt = {16'h0000, pix[23:16]};
        end
        default: begin
          emit    = 1'b1;
          data    = {pix, res[7:0]};
          keep    = KEEP_FULL;
          res_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words),
// with TLAST per line, TUSER on first word of frame and padded partial flushes.
module rgb_stream_packer
  import rgb_pack_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        sync_err
);

  state_t             state;
  phase_t             phase;
  logic [PIXEL_W-1:0] res;
  logic               sof_pend;

  logic [PIXEL_W-1:0] pix;
  phase_t             eff_phase;
  phase_t             mux_phase;
  logic [31:0]        mux_data;
  logic [3:0]         mux_keep;
  logic [PIXEL_W-1:0] mux_res;
  logic               mux_emit;
  logic               slot_free;
  logic               needs_slot;
  logic               in_fire;
  logic               flush_fire;

  assign pix = {in_r, in_g, in_b};
  // A SOF pixel always restarts packing at phase 0, whatever was pending.
  assign eff_phase  = in_sof ? 2'd0 : phase;
  assign mux_phase  = (state == FLUSH) ? phase : eff_phase;
  assign slot_free  = !out_stream_tvalid || out_stream_tready;
  assign needs_slot = (eff_phase != 2'd0) || in_eol;
  assign in_ready   = !areset && (state == ACCEPT) && (!needs_slot || slot_free);
  assign in_fire    = in_valid && in_ready;
  assign flush_fire = (state == FLUSH) && slot_free;

  rgb_pack_lane_mux #(.PAD_BYTE(PAD_BYTE)) u_mux (
    .phase   (mux_phase),
    .res     (res),
    .pix     (pix),
    .flush   (state == FLUSH),
    .eol     (in_eol),
    .data    (mux_data),
    .keep    (mux_keep),
    .res_nxt (mux_res),
    .emit    (mux_emit)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= ACCEPT;
      phase             <= 2'd0;
      res               <= '0;
      sof_pend          <= 1'b0;
      sync_err          <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tkeep  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (out_stream_tvalid && out_stream_tready)
        out_stream_tvalid <= 1'b0;

      if (flush_fire) begin
        out_stream_tdata  <= mux_data;
        out_stream_tkeep  <= mux_keep;
        out_stream_tlast  <= 1'b1;
        out_stream_tuser  <= sof_pend;
        out_stream_tvalid <= 1'b1;
        sof_pend          <= 1'b0;
        res               <= '0;
        phase             <= 2'd0;
        state             <= ACCEPT;
      end else if (in_fire) begin
        sync_err <= in_sof && (phase != 2'd0);
        res      <= mux_res;
        if (mux_emit) begin
          out_stream_tdata  <= mux_data;
          out_stream_tkeep  <= mux_keep;
          out_stream_tlast  <= in_eol && (eff_phase == 2'd0 || eff_phase == 2'd3);
          out_stream_tuser  <= sof_pend || in_sof;
          out_stream_tvalid <= 1'b1;
          sof_pend          <= 1'b0;
        end else if (in_sof) begin
          sof_pend <= 1'b1;
        end
        // EOL at phase 1/2 leaves bytes in the residual; FLUSH drains them.
        if (in_eol && (eff_phase == 2'd1 || eff_phase == 2'd2)) begin
          state <= FLUSH;
          phase <= eff_phase + 2'd1;
        end else if (in_eol) begin
          phase <= 2'd0;
        end else begin
          phase <= eff_phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Randomized bench for rgb_stream_packer against a byte-queue reference model.
module tb_rgb_stream_packer;

  localparam logic [7:0] PAD = 8'hEE;

  typedef struct packed {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
  } stim_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_valid, in_ready, in_sof, in_eol;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic        sync_err;

  int n_chk  = 0;
  int n_fail = 0;

  stim_t       stim_q[$];
  logic [37:0] exp_q[$];
  logic [37:0] obs_q[$];
  logic [7:0]  line_b[$];
  logic        sof_pend_m;
  logic        exp_sync;
  logic        hold_chk;
  logic [37:0] held;
  int          sync_cnt;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.PAD_BYTE(PAD)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .in_r              (in_r),
    .in_g              (in_g),
    .in_b              (in_b),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_sof            (in_sof),
    .in_eol            (in_eol),
    .out_stream_tdata  (tdata),
    .out_stream_tkeep  (tkeep),
    .out_stream_tlast  (tlast),
    .out_stream_tuser  (tuser),
    .out_stream_tvalid (tvalid),
    .out_stream_tready (tready),
    .sync_err          (sync_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic [31:0] d, input logic [3:0] k,
                                     input logic l, input logic u);
    return {d, k, l, u};
  endfunction

  // Reference: a line is just a byte string (3 bytes per pixel) cut into
  // 4-byte words; the tail of a line is padded and marked by its keep mask.
  task automatic model_push(input stim_t s);
    logic [31:0] d;
    int n;
    if (s.sof) begin
      if (line_b.size() != 0) exp_sync = 1'b1;
      line_b.delete();
      sof_pend_m = 1'b1;
    end
    for (int i = 0; i < 3; i++) line_b.push_back(s.pix[8*i +: 8]);
    while (line_b.size() >= 4) begin
      for (int i = 0; i < 4; i++) d[8*i +: 8] = line_b.pop_front();
      exp_q.push_back(mk(d, 4'hF, s.eol && line_b.size() == 0, sof_pend_m));
      sof_pend_m = 1'b0;
    end
    if (s.eol && line_b.size() > 0) begin
      n = line_b.size();
      d = {4{PAD}};
      for (int i = 0; i < n; i++) d[8*i +: 8] = line_b[i];
      exp_q.push_back(mk(d, 4'((1 << n) - 1), 1'b1, sof_pend_m));
      sof_pend_m = 1'b0;
      line_b.delete();
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    line_b.delete();
    sof_pend_m = 1'b0;
    exp_sync   = 1'b0;
    hold_chk   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset   = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    tready   = 1'b1;
    repeat (2) @(negedge aclk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    areset   = 1'b0;
    model_clear();
  endtask

  task automatic push_px(input logic [23:0] p, input logic sof, input logic eol);
    stim_t s;
    s.pix = p;
    s.sof = sof;
    s.eol = eol;
    stim_q.push_back(s);
  endtask

  // Drives queued pixels with random valid/ready and checks every handshake.
  task automatic run(input int vpct, input int rpct, input int max_cyc, output int ready_low);
    stim_t cur;
    logic  have;
    logic [37:0] w;
    int    cyc;
    have = 1'b0;
    cyc = 0;
    ready_low = 0;
    cur = '0;
    while ((stim_q.size() > 0 || have || exp_q.size() > 0) && cyc < max_cyc) begin
      @(negedge aclk);
      if (hold_chk) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_word", {tdata, tkeep, tlast, tuser}, held);
      end
      chk("sync_err", sync_err, exp_sync);
      if (sync_err) sync_cnt++;
      if (!have && stim_q.size() > 0) begin
        cur  = stim_q.pop_front();
        have = 1'b1;
      end
      in_valid = have && ($urandom_range(99) < vpct);
      {in_r, in_g, in_b} = cur.pix;
      in_sof = cur.sof;
      in_eol = cur.eol;
      tready = ($urandom_range(99) < rpct);
      #1;
      if (in_valid && !in_ready) ready_low++;
      w = {tdata, tkeep, tlast, tuser};
      if (tvalid && tready) begin
        obs_q.push_back(w);
        if (exp_q.size() == 0) chk("extra_word", w, 0);
        else chk("word", w, exp_q.pop_front());
      end
      hold_chk = tvalid && !tready;
      held     = w;
      exp_sync = 1'b0;
      if (in_valid && in_ready) begin
        model_push(cur);
        have = 1'b0;
      end
      cyc++;
    end
    if (cyc >= max_cyc) chk("timeout", cyc, 0);
    in_valid = 1'b0;
    tready   = 1'b1;
    @(negedge aclk);
    chk("sync_err", sync_err, exp_sync);
    if (sync_err) sync_cnt++;
    exp_sync = 1'b0;
    hold_chk = 1'b0;
    chk("idle_tvalid", tvalid, 0);
  endtask

  initial begin
    int rl, nlast, lastidx;
    logic [37:0] o;
    areset = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    tready = 1'b1;
    sync_cnt = 0;
    held = '0;
    model_clear();
    do_reset();

    // Four-pixel line with SOF: three full words.
    obs_q.delete();
    push_px(24'h030201, 1, 0);
    push_px(24'h060504, 0, 0);
    push_px(24'h090807, 0, 0);
    push_px(24'h0C0B0A, 0, 1);
    run(100, 100, 200, rl);
    chk("l4_stall", rl, 0);
    chk("l4_nwords", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("l4_w0", obs_q[0], mk(32'h04030201, 4'hF, 0, 1));
      chk("l4_w1", obs_q[1], mk(32'h08070605, 4'hF, 0, 0));
      chk("l4_w2", obs_q[2], mk(32'h0C0B0A09, 4'hF, 1, 0));
    end

    // Two-pixel line (FLUSH) followed by a one-pixel SOF+EOL line.
    obs_q.delete();
    push_px(24'h112233, 0, 0);
    push_px(24'h445566, 0, 1);
    push_px(24'hAABBCC, 1, 1);
    run(100, 100, 200, rl);
    chk("flush_stall", rl, 1);
    chk("l2_nwords", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("l2_w0", obs_q[0], mk(32'h66112233, 4'hF, 0, 0));
      chk("l2_w1", obs_q[1], mk(32'hEEEE4455, 4'h3, 1, 0));
      chk("l1_w0", obs_q[2], mk(32'hEEAABBCC, 4'h7, 1, 1));
    end

    // 640-pixel line under random back-pressure.
    obs_q.delete();
    for (int i = 0; i < 640; i++)
      push_px(24'($urandom), i == 0, i == 639);
    run(80, 50, 20000, rl);
    nlast = 0;
    lastidx = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      o = obs_q[i];
      if (o[1]) begin nlast++; lastidx = i; end
    end
    chk("l640_nwords", obs_q.size(), 480);
    chk("l640_nlast", nlast, 1);
    chk("l640_lastidx", lastidx, 479);

    // SOF arriving at phase 2 resynchronises.
    obs_q.delete();
    sync_cnt = 0;
    push_px(24'h0A0B0C, 0, 0);
    push_px(24'h0D0E0F, 0, 0);
    push_px(24'h515253, 1, 0);
    push_px(24'h616263, 0, 0);
    push_px(24'h717273, 0, 0);
    push_px(24'h818283, 0, 1);
    run(100, 70, 400, rl);
    chk("resync_pulses", sync_cnt, 1);
    chk("resync_nwords", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      o = obs_q[1];
      chk("resync_first_pix", o[29:6], 24'h515253);
      chk("resync_tuser", o[0], 1);
    end

    // Reset while in FLUSH with output stalled.
    @(negedge aclk);
    tready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b0; in_eol = 1'b0;
    {in_r, in_g, in_b} = 24'h112233;
    @(negedge aclk);
    in_eol = 1'b1;
    {in_r, in_g, in_b} = 24'h445566;
    @(negedge aclk);
    in_valid = 1'b0;
    in_eol = 1'b0;
    chk("flush_tvalid", tvalid, 1);
    chk("flush_in_ready", in_ready, 0);
    #1 areset = 1'b1;
    #1;
    chk("rst_async_tvalid", tvalid, 0);
    chk("rst_async_in_ready", in_ready, 0);
    @(negedge aclk);
    areset = 1'b0;
    model_clear();
    obs_q.delete();
    push_px(24'h030201, 0, 0);
    push_px(24'h060504, 0, 0);
    push_px(24'h090807, 0, 0);
    push_px(24'h0C0B0A, 0, 1);
    run(100, 100, 200, rl);
    chk("post_rst_nwords", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("post_rst_w0", obs_q[0], mk(32'h04030201, 4'hF, 0, 0));
      chk("post_rst_w2", obs_q[2], mk(32'h0C0B0A09, 4'hF, 1, 0));
    end

    // Mixed random lines with random SOF/EOL placement.
    for (int i = 0; i < 300; i++)
      push_px(24'($urandom), $urandom_range(99) < 5, $urandom_range(99) < 12);
    push_px(24'($urandom), 0, 1);
    run(70, 60, 20000, rl);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
